// File: rtl/motor_sched_pkg.sv
// motor_sched_pkg: shared definitions for the stepper-motor move scheduler.
//   - sched_state_e : scheduler FSM encoding (idle, motor running, idle gap)
//   - Def*          : default timing constants used as parameter defaults
//   - max_u         : elaboration-time helper for sizing the shared run/gap counter
package motor_sched_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StGap  = 2'd2
    } sched_state_e;

    localparam int unsigned DefNReq       = 2;
    localparam int unsigned DefQualCycles = 5;
    localparam int unsigned DefRunCycles  = 20000000;
    localparam int unsigned DefGapCycles  = 1000000;
    localparam int unsigned DefPendW      = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/req_qualifier.sv
// req_qualifier: held-high filter for one requester strobe line.
//   CLK    : system clock
//   RST    : synchronous active-high reset
//   STB    : raw level-sensitive strobe
//   ACCEPT : one-cycle pulse on the QUAL_CYCLES-th consecutive high cycle of a press
// The count saturates at QUAL_CYCLES while the strobe stays high, so a held
// button yields exactly one accept; any low cycle restarts the count.
module req_qualifier
    import motor_sched_pkg::*;
#(
    parameter int unsigned QUAL_CYCLES = DefQualCycles
) (
    input  logic CLK,
    input  logic RST,
    input  logic STB,
    output logic ACCEPT
);

    localparam int unsigned QW = $clog2(QUAL_CYCLES + 1);
    localparam logic [QW-1:0] QualMax  = QW'(QUAL_CYCLES);
    localparam logic [QW-1:0] QualLast = QW'(QUAL_CYCLES - 1);

    logic [QW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!STB) begin
            cnt_d = '0;
        end else if (cnt_q != QualMax) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Fires in the cycle whose closing edge brings the count to QUAL_CYCLES,
    // letting the arbiter grant on that same edge.
    assign ACCEPT = STB && (cnt_q == QualLast);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/motor_move_scheduler.sv
// motor_move_scheduler: queues qualified move requests and drives the motor
// driver's single mover enable with fixed-length runs, round-robin between
// requesters, with an idle gap after every run.
//   CLK      : system clock
//   RST      : synchronous active-high reset (drops MOVER immediately, clears queue)
//   STB      : raw request strobes, one per requester
//   ENABLE   : gates the start of new runs only
//   MOVER    : high for exactly RUN_CYCLES per granted run
//   BUSY     : high while running or in the post-run gap
//   GRANT    : one-hot owner of the current or last run
//   DONE     : one-cycle pulse on the first cycle after a run
//   OVF      : one-cycle pulse when a press is dropped on a saturated pending count
//   PEND_ANY : any requester has queued runs
module motor_move_scheduler
    import motor_sched_pkg::*;
#(
    parameter int unsigned N_REQ       = DefNReq,
    parameter int unsigned QUAL_CYCLES = DefQualCycles,
    parameter int unsigned RUN_CYCLES  = DefRunCycles,
    parameter int unsigned GAP_CYCLES  = DefGapCycles,
    parameter int unsigned PEND_W      = DefPendW
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] STB,
    input  logic             ENABLE,
    output logic             MOVER,
    output logic             BUSY,
    output logic [N_REQ-1:0] GRANT,
    output logic             DONE,
    output logic             OVF,
    output logic             PEND_ANY
);

    localparam int unsigned PW         = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CntW       = $clog2(max_u(RUN_CYCLES, GAP_CYCLES) + 1);
    localparam int unsigned GapLastInt = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [CntW-1:0]   RunLast = CntW'(RUN_CYCLES - 1);
    localparam logic [CntW-1:0]   GapLast = CntW'(GapLastInt);
    localparam logic [PEND_W-1:0] PendMax = '1;
    localparam logic [PW-1:0]     LastIdx = PW'(N_REQ - 1);

    sched_state_e state_q, state_d;

    logic [CntW-1:0]              cnt_q, cnt_d;
    logic [PW-1:0]                ptr_q, ptr_d;
    logic [N_REQ-1:0]             grant_q, grant_d;
    logic [N_REQ-1:0][PEND_W-1:0] pend_q, pend_d;
    logic                         done_q, done_d;
    logic                         ovf_q, ovf_d;

    logic [N_REQ-1:0] accept;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] win_onehot;
    logic [N_REQ-1:0] win_hit;
    logic [PW-1:0]    win_idx;
    logic             win_found;
    logic             grant_fire;
    int unsigned      cand;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_qual
        req_qualifier #(
            .QUAL_CYCLES (QUAL_CYCLES)
        ) u_qual (
            .CLK    (CLK),
            .RST    (RST),
            .STB    (STB[gi]),
            .ACCEPT (accept[gi])
        );
    end

    // A same-cycle accept counts as a request so an idle scheduler starts the
    // run on the accept edge without first parking it in the pending count.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req[i] = (pend_q[i] != '0) || accept[i];
        end
    end

    // Round-robin search starting at the pointer, wrapping past N_REQ-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = 32'(ptr_q) + 32'(k);
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!win_found && req[PW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = PW'(cand);
            end
        end
    end

    assign win_onehot = N_REQ'(1) << win_idx;
    assign grant_fire = (state_q == StIdle) && ENABLE && win_found;
    assign win_hit    = grant_fire ? win_onehot : '0;

    always_comb begin
        ptr_d   = ptr_q;
        grant_d = grant_q;
        if (grant_fire) begin
            ptr_d   = (win_idx == LastIdx) ? '0 : win_idx + 1'b1;
            grant_d = win_onehot;
        end
    end

    // Accept and grant on the same requester cancel, so no overflow is
    // possible in that case even when the count is saturated.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (accept[i] && !win_hit[i]) begin
                if (pend_q[i] == PendMax) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] + 1'b1;
                end
            end else if (win_hit[i] && !accept[i]) begin
                pend_d[i] = pend_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant_fire) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                if (cnt_q == RunLast) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            pend_q  <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign MOVER    = (state_q == StRun);
    assign BUSY     = (state_q == StRun) || (state_q == StGap);
    assign GRANT    = grant_q;
    assign DONE     = done_q;
    assign OVF      = ovf_q;
    assign PEND_ANY = |pend_q;

endmodule

// File: tb/tb_motor_move_scheduler.sv
// tb_motor_move_scheduler: directed bench for motor_move_scheduler with
// RUN_CYCLES=8, GAP_CYCLES=3, QUAL_CYCLES=5, N_REQ=2, PEND_W=2.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_motor_move_scheduler;

    logic       clk;
    logic       rst;
    logic [1:0] stb;
    logic       enable;
    logic       mover;
    logic       busy;
    logic [1:0] grant;
    logic       done;
    logic       ovf;
    logic       pend_any;

    int n_checks;
    int n_errors;

    motor_move_scheduler #(
        .N_REQ       (2),
        .QUAL_CYCLES (5),
        .RUN_CYCLES  (8),
        .GAP_CYCLES  (3),
        .PEND_W      (2)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .STB      (stb),
        .ENABLE   (enable),
        .MOVER    (mover),
        .BUSY     (busy),
        .GRANT    (grant),
        .DONE     (done),
        .OVF      (ovf),
        .PEND_ANY (pend_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        stb    = 2'b00;
        enable = 1'b1;
        ticks(2);
        rst = 1'b0;
    endtask

    // Counts consecutive MOVER-high samples, bounded.
    task automatic count_high(output int n);
        n = 0;
        while (mover === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    // Counts MOVER-low samples until it rises, bounded.
    task automatic count_low(output int n);
        n = 0;
        while (mover !== 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    int hi;
    int lo;
    int seen;
    int ovf_cnt;
    int ovf_on_last;
    int runs;
    logic prev_mover;

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Reset state
        do_reset();
        check_eq("rst_mover", 32'(mover), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_grant", 32'(grant), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_ovf", 32'(ovf), 0);
        check_eq("rst_pend_any", 32'(pend_any), 0);

        // 1. Single press, STB[0] held for 10 cycles
        stb = 2'b01;
        ticks(4);
        check_eq("t1_mover_before_accept", 32'(mover), 0);
        tick();
        check_eq("t1_mover_rise", 32'(mover), 1);
        check_eq("t1_grant", 32'(grant), 32'h1);
        check_eq("t1_busy_run", 32'(busy), 1);
        check_eq("t1_pend_any", 32'(pend_any), 0);
        hi = 0;
        while (mover === 1'b1 && hi < 100) begin
            hi++;
            if (hi == 6) stb = 2'b00;
            tick();
        end
        check_eq("t1_run_len", 32'(hi), 8);
        check_eq("t1_done_pulse", 32'(done), 1);
        check_eq("t1_busy_gap", 32'(busy), 1);
        tick();
        check_eq("t1_done_width", 32'(done), 0);
        ticks(2);
        check_eq("t1_busy_end", 32'(busy), 0);
        check_eq("t1_grant_held", 32'(grant), 32'h1);

        // 2. Glitch rejection
        do_reset();
        seen = 0;
        stb = 2'b01;
        for (int i = 0; i < 4; i++) begin tick(); seen += int'(mover); end
        stb = 2'b00;
        tick();
        seen += int'(mover);
        stb = 2'b01;
        for (int i = 0; i < 4; i++) begin tick(); seen += int'(mover); end
        stb = 2'b00;
        for (int i = 0; i < 4; i++) begin tick(); seen += int'(mover); end
        check_eq("t2_no_mover", 32'(seen), 0);
        check_eq("t2_pend_any", 32'(pend_any), 0);

        // 3. Round-robin, both requesters qualify together
        do_reset();
        stb = 2'b11;
        ticks(5);
        stb = 2'b00;
        check_eq("t3_grant_first", 32'(grant), 32'h1);
        check_eq("t3_pend_any_queued", 32'(pend_any), 1);
        count_high(hi);
        check_eq("t3_run1_len", 32'(hi), 8);
        count_low(lo);
        check_eq("t3_between_runs", 32'(lo), 4);
        check_eq("t3_grant_second", 32'(grant), 32'h2);
        check_eq("t3_pend_any_empty", 32'(pend_any), 0);
        count_high(hi);
        check_eq("t3_run2_len", 32'(hi), 8);

        // 4. Saturation with ENABLE low
        do_reset();
        enable      = 1'b0;
        ovf_cnt     = 0;
        ovf_on_last = 0;
        seen        = 0;
        for (int p = 0; p < 4; p++) begin
            stb = 2'b10;
            for (int i = 0; i < 5; i++) begin
                tick();
                ovf_cnt += int'(ovf);
                seen    += int'(mover);
            end
            if (p == 3) ovf_on_last = int'(ovf);
            stb = 2'b00;
            tick();
            ovf_cnt += int'(ovf);
            seen    += int'(mover);
        end
        check_eq("t4_ovf_count", 32'(ovf_cnt), 1);
        check_eq("t4_ovf_on_4th", 32'(ovf_on_last), 1);
        check_eq("t4_no_run_disabled", 32'(seen), 0);
        check_eq("t4_pend_any", 32'(pend_any), 1);
        enable     = 1'b1;
        runs       = 0;
        prev_mover = mover;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (mover === 1'b1 && prev_mover !== 1'b1) runs++;
            prev_mover = mover;
        end
        check_eq("t4_runs", 32'(runs), 3);
        check_eq("t4_grant", 32'(grant), 32'h2);
        check_eq("t4_pend_drained", 32'(pend_any), 0);

        // 5. Reset on the 4th RUN cycle
        do_reset();
        stb = 2'b11;
        ticks(5);
        stb = 2'b00;
        check_eq("t5_running", 32'(mover), 1);
        check_eq("t5_pend_before", 32'(pend_any), 1);
        ticks(3);
        rst = 1'b1;
        tick();
        check_eq("t5_mover", 32'(mover), 0);
        check_eq("t5_busy", 32'(busy), 0);
        check_eq("t5_grant", 32'(grant), 0);
        check_eq("t5_pend_any", 32'(pend_any), 0);
        seen = int'(done);
        rst  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen += int'(done) + int'(mover);
        end
        check_eq("t5_no_done", 32'(seen), 0);

        // 6. ENABLE dropped mid-run, request queued meanwhile
        do_reset();
        stb = 2'b01;
        ticks(5);
        check_eq("t6_running", 32'(mover), 1);
        hi = 0;
        while (mover === 1'b1 && hi < 100) begin
            hi++;
            if (hi == 1) stb = 2'b00;
            if (hi == 3) begin
                enable = 1'b0;
                stb    = 2'b10;
            end
            if (hi == 8) stb = 2'b00;
            tick();
        end
        check_eq("t6_run_len", 32'(hi), 8);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen += int'(mover);
        end
        check_eq("t6_held_off", 32'(seen), 0);
        check_eq("t6_busy", 32'(busy), 0);
        check_eq("t6_pending", 32'(pend_any), 1);
        enable = 1'b1;
        tick();
        check_eq("t6_mover_rise", 32'(mover), 1);
        check_eq("t6_grant", 32'(grant), 32'h2);
        check_eq("t6_pend_drained", 32'(pend_any), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/motor_move_scheduler.md
Name: motor_move_scheduler

Overview:
- Sequences the stepper-motor driver: accepts move requests from N_REQ push-button/strobe sources and drives the driver's single `mover` enable input.
- Each requester line is qualified (held-high filter, one request per press), and requests are queued as per-requester pending counts.
- A round-robin arbiter grants one fixed-length motor run at a time, with an idle gap enforced between runs.
- Sits between the board strobe inputs and the Motor phase-driver instance.

Parameters:
- N_REQ, 2, number of requester strobe lines.
- QUAL_CYCLES, 5, consecutive high cycles required to accept a press (>=1).
- RUN_CYCLES, 20000000, cycles MOVER is held high per granted run (>=1).
- GAP_CYCLES, 1000000, idle cycles after a run before the next grant (>=0).
- PEND_W, 2, width of each per-requester pending counter; saturates at 2^PEND_W-1.

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous, active-high reset.
- STB  input  N_REQ  raw request strobes, one per requester, level-sensitive.
- ENABLE  input  1  when low, no new run starts; a run in progress completes.
- MOVER  output  1  to Motor `mover` input; high for exactly RUN_CYCLES per run.
- BUSY  output  1  high in RUN and GAP states.
- GRANT  output  N_REQ  one-hot owner of the current or last run; 0 after reset.
- DONE  output  1  one-cycle pulse on the first cycle after a run ends.
- OVF  output  1  one-cycle pulse when an accepted press is dropped because that requester's counter is saturated.
- PEND_ANY  output  1  high when any pending counter is non-zero.

Behaviour:
- Reset (synchronous, RST high at a CLK edge):
  - State = IDLE.
  - All counters and qualifiers = 0; pending counts = 0; round-robin pointer = 0.
  - MOVER, BUSY, DONE, OVF = 0; GRANT = 0.
  - Reset mid-run takes MOVER low on that edge; no DONE pulse is issued.
- Qualification (per requester, registered):
  - The count increments each cycle STB[i] is high and clears to 0 whenever STB[i] is low.
  - A press is accepted on the cycle the count reaches QUAL_CYCLES. The count then holds, so only one accept per press, until STB[i] goes low.
  - A glitch shorter than QUAL_CYCLES is ignored.
- Pending counters:
  - An accept increments pending[i]. If pending[i] is at max, the press is dropped and OVF pulses.
  - A grant decrements the granted requester's pending count.
  - Accept and grant on the same requester in the same cycle leave the count unchanged and do not raise OVF, even at max.
- FSM, IDLE -> RUN:
  - Taken when ENABLE=1 and any pending count is non-zero.
  - The winner is the first requester with pending>0, searching from the round-robin pointer upward with wrap-around.
  - On the transition edge: GRANT = one-hot winner, pending[winner] decrements, pointer = (winner+1) mod N_REQ, run counter cleared.
  - MOVER and BUSY are high from the next cycle.
  - Latency: qualifying accept cycle -> MOVER high is 1 cycle when IDLE and enabled.
- FSM, RUN -> GAP:
  - MOVER stays high for exactly RUN_CYCLES cycles, then the FSM moves to GAP.
  - DONE pulses on the first GAP cycle.
  - If GAP_CYCLES=0, the FSM goes RUN -> IDLE directly, DONE pulses on the first IDLE cycle, and a new grant may be taken on that same edge.
- FSM, GAP -> IDLE:
  - Taken after GAP_CYCLES cycles. BUSY is low in IDLE.
- ENABLE behaviour:
  - ENABLE low during RUN or GAP does not truncate either state.
  - Pending counts are retained while ENABLE is low.
  - Qualification and accepts continue in every state while ENABLE is low.
- Widths and counters:
  - The run/gap counter is one shared counter, width $clog2(max(RUN_CYCLES,GAP_CYCLES)+1), reloaded at each state entry.
  - The qualifier counter width is $clog2(QUAL_CYCLES+1).

Decomposition:
- Package motor_sched_pkg: FSM state encoding (IDLE, RUN, GAP) and default timing constants.
- Sub-module req_qualifier, instantiated N_REQ times. Inputs: CLK, RST, STB. Output: a one-cycle accept pulse.
- Arbiter, pending counters and FSM stay in the top module.

Test Plan:
Bench parameters for all scenarios: RUN_CYCLES=8, GAP_CYCLES=3, QUAL_CYCLES=5, N_REQ=2.
1. Single press: STB[0] high for 10 cycles -> accept on the 5th high cycle, MOVER high for exactly 8 cycles starting the next cycle, GRANT=01, DONE pulse 1 cycle after MOVER falls, BUSY low 3 cycles later.
2. Glitch rejection: STB[0] high 4 cycles, low, high 4 cycles -> no accept, MOVER stays 0, PEND_ANY=0.
3. Round-robin: both STB qualify in the same cycle -> first run GRANT=01, second run GRANT=10. The two runs are separated by exactly 3 idle cycles plus 1 grant cycle.
4. Saturation: four presses on STB[1] while ENABLE=0 -> pending[1]=3, OVF pulses once on the 4th accept. Raising ENABLE then yields exactly 3 runs.
5. Reset mid-run: RST asserted on cycle 4 of RUN -> MOVER=0, BUSY=0, GRANT=0 after that edge, no DONE pulse, PEND_ANY=0.
6. ENABLE dropped mid-run: the run completes its full 8 MOVER cycles. A queued request stays pending until ENABLE returns, and MOVER rises 1 cycle after ENABLE goes high.
